// File: rtl/unidad_fetch_pkg.sv
// fetch_pkg: shared widths, instruction field positions, opcode encodings
// and the fetch state enum for the unidad_fetch instruction fetch stage.
// Ports: none (package).
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 18;

  // Instruction layout: {rs1, rs2, rd, op}
  localparam int RS1_HI = 17;
  localparam int RS1_LO = 13;
  localparam int RS2_HI = 12;
  localparam int RS2_LO = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 3;
  localparam int OP_HI  = 2;
  localparam int OP_LO  = 0;

  localparam logic [2:0] OP_SUMA = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/unidad_fetch_if.sv
// unidad_fetch_if: bundles the instruction-memory port, redirect request and
// the decode-facing valid/ready output of the fetch stage.
// Modports:
//   master - fetch stage side (drives mem_addr, out_*, halted, stall_count)
//   slave  - environment side (memory, decode, control)
// Optional: stall_count exists only when FETCH_STALL_CNT_EN is defined.
interface unidad_fetch_if;
  import fetch_pkg::*;

  logic                en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [INSTR_W-1:0]  mem_instr;
  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_addr;
  logic                out_valid;
  logic                out_ready;
  logic [INSTR_W-1:0]  out_instr;
  logic [ADDR_W-1:0]   out_pc;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [4:0]          out_rd;
  logic [2:0]          out_op;
  logic                halted;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]         stall_count;
`endif

  modport master (
    input  en, mem_instr, redirect_valid, redirect_addr, out_ready,
    output mem_addr, out_valid, out_instr, out_pc,
    output out_rs1, out_rs2, out_rd, out_op, halted
`ifdef FETCH_STALL_CNT_EN
    , output stall_count
`endif
  );

  modport slave (
    output en, mem_instr, redirect_valid, redirect_addr, out_ready,
    input  mem_addr, out_valid, out_instr, out_pc,
    input  out_rs1, out_rs2, out_rd, out_op, halted
`ifdef FETCH_STALL_CNT_EN
    , input stall_count
`endif
  );

endinterface

// File: rtl/unidad_fetch_registro_salida.sv
// registro_salida: valid/ready output register of the fetch stage. Holds the
// fetched instruction and its PC until decode accepts it.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   load             capture d_instr/d_pc and mark valid
//   flush            drop the held instruction (wins over load)
//   ready            decode accepts the held instruction this cycle
//   d_instr, d_pc    data to capture
//   valid, instr, pc registered output
module registro_salida
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic               ready,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = d_instr;
      pc_d    = d_pc;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction fetch stage. Owns the PC, addresses a
// combinational-read instruction memory, registers each word with its PC and
// presents it to decode via valid/ready. Supports redirect-with-flush and
// halts after delivering the instruction at PC_LAST.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         unidad_fetch_if.master (memory, redirect, output handshake)
// Optional: define FETCH_STALL_CNT_EN to add a saturating 16-bit stall_count.
//
// state | meaning
// IDLE  | after reset, waiting for en; no loads
// FETCH | loading one instruction per cycle when output register frees up
// HALT  | PC_LAST has been loaded; no further loads until a redirect
module unidad_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(255)
) (
  input  logic           clk,
  input  logic           rst_n,
  unidad_fetch_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               load;
  logic               flush;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A redirect in IDLE only retargets the PC; fetch still waits for en.
        if (bus.redirect_valid) pc_d = bus.redirect_addr;
        else if (bus.en)        state_d = FETCH;
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_d  = bus.redirect_addr;
          flush = 1'b1;
        end else if (!out_valid || bus.out_ready) begin
          load = 1'b1;
          pc_d = pc_q + ADDR_W'(1);
          if (pc_q == PC_LAST) state_d = HALT;
        end
      end
      HALT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_addr;
          flush   = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  registro_salida u_registro_salida (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .ready   (bus.out_ready),
    .d_instr (bus.mem_instr),
    .d_pc    (pc_q),
    .valid   (out_valid),
    .instr   (out_instr),
    .pc      (out_pc)
  );

  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_instr;
  assign bus.out_pc    = out_pc;
  assign bus.out_rs1   = out_instr[RS1_HI:RS1_LO];
  assign bus.out_rs2   = out_instr[RS2_HI:RS2_LO];
  assign bus.out_rd    = out_instr[RD_HI:RD_LO];
  assign bus.out_op    = out_instr[OP_HI:OP_LO];
  assign bus.halted    = (state_q == HALT);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/unidad_fetch.md
# unidad_fetch

Instruction fetch stage: owns the program counter and drives the read address of the instruction memory, which is an 8-bit-address, 18-bit-word, combinational-read array. Each returned word is registered together with its PC and split into fields {rs1[17:13], rs2[12:8], rd[7:3], op[2:0]}. The result is presented to decode through a valid/ready handshake. Supports redirect (jump) with flush, and halts after a configurable last address.

## Interface
- ADDR_W, 8, PC and memory address width
- INSTR_W, 18, instruction width
- PC_RESET, 0, PC value after reset
- PC_LAST, 255, address of the final instruction; fetch halts after delivering it

Ports:
- clk  in  1  rising-edge clock, the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request, sampled only in IDLE
- mem_addr  out  ADDR_W  read address to instruction memory, equal to the PC register
- mem_instr  in  INSTR_W  instruction word returned combinationally for mem_addr
- redirect_valid  in  1  load a new PC and flush
- redirect_addr  in  ADDR_W  target PC
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  decode accepts the instruction
- out_instr  out  INSTR_W  registered instruction word
- out_pc  out  ADDR_W  address of out_instr
- out_rs1, out_rs2, out_rd  out  5 each  fields of out_instr
- out_op  out  3  opcode field: 000 SUMA, 001 AND, 010 OR
- halted  out  1  high while in HALT
- stall_count  out  16  present only with FETCH_STALL_CNT_EN

## Operation
- States:
  - IDLE: reset state, no loads.
  - FETCH: loading instructions.
  - HALT: PC_LAST delivered, no further loads.
- IDLE -> FETCH when en=1.
- In FETCH, a load occurs when out_valid=0 or out_ready=1. A load does:
  - out_instr <= mem_instr
  - out_pc <= pc
  - out_valid <= 1
  - pc <= pc+1, modulo 2^ADDR_W
- A load with pc==PC_LAST moves FETCH -> HALT. That instruction is still delivered.
- In HALT:
  - out_valid clears once the held instruction is accepted.
  - halted=1.
- Redirect has priority over a load in every state:
  - pc <= redirect_addr.
  - In FETCH or HALT: out_valid <= 0 (the held instruction is discarded even if out_ready=1 that cycle), and the state goes to FETCH.
  - In IDLE: the state stays IDLE.
- Output fields are pure bit-slices of out_instr. Unknown memory contents are passed through unchanged.
- en is ignored outside IDLE.

## Timing
- Reset values:
  - pc=PC_RESET, state=IDLE
  - out_valid=0, out_instr=0, out_pc=0, all fields 0
  - halted=0, stall_count=0
- Latency: the instruction at address A is visible on out_* at the first rising edge after the FETCH cycle in which pc=A.
- Throughput is one instruction per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_* and pc hold stable.
- Redirect latency: the first instruction from redirect_addr appears two edges after redirect_valid is sampled. out_valid is 0 in between.
- Reset asserted mid-operation clears everything immediately, with no handshake completion.
- mem_addr changes only on clk edges, never combinationally from the inputs.

## Configuration
- FETCH_STALL_CNT_EN defined:
  - stall_count increments each cycle with out_valid=1 and out_ready=0.
  - It saturates at 16'hFFFF.
  - Only reset clears it.
- FETCH_STALL_CNT_EN undefined: the port and the counter are absent.

## Structure
- Package fetch_pkg holds:
  - ADDR_W and INSTR_W defaults
  - field bit positions (RS1_HI/LO, RS2_HI/LO, RD_HI/LO, OP_HI/LO)
  - opcode constants OP_SUMA, OP_AND, OP_OR
  - the state enum {IDLE, FETCH, HALT}
- Sub-module registro_salida holds the valid/ready output register:
  - load, flush and ready inputs
  - instruction and PC storage

## Test plan
- Reset, en=1, memory {0,1,2,000}@0, {3,4,5,001}@1, out_ready=1 -> cycle 2 after en: out_pc=0, rs1=0, rs2=1, rd=2, op=000. Next cycle: out_pc=1, rd=5, op=001.
- out_ready=0 for 3 cycles while out_valid=1 -> out_pc and mem_addr stable. stall_count=3 when FETCH_STALL_CNT_EN is defined.
- redirect_valid with redirect_addr=4, while out_pc=1 is held with out_ready=0 -> out_valid=0 next cycle, then out_pc=4 with rd=14, op=001.
- PC_LAST=5, free-running fetch -> instruction at 5 is delivered, halted=1, out_valid=0 after acceptance, mem_addr stays 6.
- PC_LAST=255, redirect to 254 -> delivers 254, then 255, then halts. pc wraps to 0 with no further load.
- rst_n low mid-stream while out_valid=1 -> out_valid=0 and pc=PC_RESET immediately, without a clock edge.
